// File: rtl/keypad_pkg.sv
// Shared types, key codes and lookup helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    PRESS,
    HOLD,
    RELEASE
  } state_e;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  function automatic logic [3:0] key_code(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    k = KEY_0;
    case ({r, c})
      4'h0: k = KEY_1;
      4'h1: k = KEY_2;
      4'h2: k = KEY_3;
      4'h3: k = KEY_A;
      4'h4: k = KEY_4;
      4'h5: k = KEY_5;
      4'h6: k = KEY_6;
      4'h7: k = KEY_B;
      4'h8: k = KEY_7;
      4'h9: k = KEY_8;
      4'hA: k = KEY_9;
      4'hB: k = KEY_C;
      4'hC: k = KEY_STAR;
      4'hD: k = KEY_0;
      4'hE: k = KEY_HASH;
      4'hF: k = KEY_D;
      default: k = KEY_0;
    endcase
    return k;
  endfunction

  // Lowest-numbered active-low row wins when several are pressed.
  function automatic logic [1:0] low_row(
    input logic [3:0] rows
  );
    logic [1:0] r;
    r = 2'd3;
    priority case (1'b1)
      !rows[0]: r = 2'd0;
      !rows[1]: r = 2'd1;
      !rows[2]: r = 2'd2;
      default:  r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic-width two-flop synchroniser with a selectable reset value.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and key encoding.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] tecla,
  output logic       ready,
  output logic       key_held
);

  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CYCLES)
                      ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [1:0]    ridx_q, ridx_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    tecla_q, tecla_d;
  logic          held_q, held_d;

  logic [3:0]    row_s;
  logic          row_hi;
  logic [1:0]    hit_row;

  sync2 #(
    .W       (4),
    .RST_VAL (4'hF)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (row),
    .q_o   (row_s)
  );

  assign row_hi  = row_s[ridx_q];
  assign hit_row = low_row(row_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cidx_d  = cidx_q;
    ridx_d  = ridx_q;
    code_d  = code_q;
    tecla_d = tecla_q;
    held_d  = held_q;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (row_s != 4'hF) begin
            ridx_d  = hit_row;
            code_d  = key_code(hit_row, cidx_q);
            state_d = DEBOUNCE;
          end else begin
            cidx_d = cidx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_hi) begin
          cnt_d   = '0;
          cidx_d  = cidx_q + 2'd1;
          state_d = SCAN;
        end else if (cnt_q == DB_LAST) begin
          // Load tecla now so it is valid during the ready cycle.
          cnt_d   = '0;
          tecla_d = code_q;
          held_d  = 1'b1;
          state_d = PRESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (row_hi) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!row_hi) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          held_d  = 1'b0;
          cidx_d  = cidx_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      cidx_q  <= '0;
      ridx_q  <= '0;
      code_q  <= '0;
      tecla_q <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cidx_q  <= cidx_d;
      ridx_q  <= ridx_d;
      code_q  <= code_d;
      tecla_q <= tecla_d;
      held_q  <= held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          rep_hit;

  assign rep_hit = (state_q == HOLD) && (rep_q == REP_LAST);

  // Held at zero outside HOLD, so every entry to HOLD starts afresh.
  always_comb begin
    rep_d = '0;
    if (state_q == HOLD && !rep_hit) begin
      rep_d = rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign ready = (state_q == PRESS) || rep_hit;
`else
  assign ready = (state_q == PRESS);
`endif

  assign col      = ~(4'b0001 << cidx_q);
  assign tecla    = tecla_q;
  assign key_held = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner with a matrix keypad model.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DB  = 8;
  localparam int RP  = 32;
  localparam int ACC = SD + DB;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] tecla;
  logic       ready;
  logic       key_held;

  logic [15:0] closed;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic prev_ready = 1'b0;

  int keymap [16] = '{1, 2, 3, 10,
                      4, 5, 6, 11,
                      7, 8, 9, 12,
                      14, 0, 15, 13};

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .tecla    (tecla),
    .ready    (ready),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A closed switch at (r,c) pulls row r low while column c is driven low.
  assign row[0] = ~|(closed[3:0]   & ~col);
  assign row[1] = ~|(closed[7:4]   & ~col);
  assign row[2] = ~|(closed[11:8]  & ~col);
  assign row[3] = ~|(closed[15:12] & ~col);

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (reset && ready) begin
      checks++;
      if (prev_ready) begin
        errors++;
        $display("FAIL ready_twice actual=1 required=0");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready tecla=%0d required=none",
                 tecla);
      end else begin
        e = exp_q.pop_front();
        if (int'(tecla) != e) begin
          errors++;
          $display("FAIL tecla actual=%0d required=%0d", tecla, e);
        end
      end
    end
    prev_ready = ready;
  end

  // Ready pulses expected for a key pressed at the start of its column
  // slot and held h cycles: the press, plus one per full repeat period.
  function automatic int pulses(input int h);
`ifdef KEYPAD_REPEAT_EN
    return 1 + (h + 2 - ACC) / RP;
`else
    return 1 + 0 * h;
`endif
  endfunction

  task automatic wait_col(input int c);
    logic [3:0] tgt;
    logic [3:0] prv;
    bit         found;
    tgt   = ~(4'b0001 << c);
    prv   = col;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (col == tgt && prv != tgt) found = 1'b1;
      prv = col;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_col actual=%0d required=%0d", col, tgt);
    end
  endtask

  task automatic press(input int k, input int h);
    int n;
    wait_col(k % 4);
    n = pulses(h);
    for (int i = 0; i < n; i++) exp_q.push_back(keymap[k]);
    closed[k] = 1'b1;
    repeat (h) @(negedge clk);
    closed[k] = 1'b0;
  endtask

  task automatic drain(input string nm);
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    int changes;
    int early;
    int k;
    int h;
    int m;
    logic [3:0] pc;

    closed = '0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_tecla", tecla, 0);
    chk("rst_ready", ready, 0);
    chk("rst_held", key_held, 0);
    reset = 1'b1;

    // Key '6' held 60 cycles.
    press(6, 60);
    repeat (8) @(negedge clk);
    chk("t1_held_rel", key_held, 1);
    repeat (5) @(negedge clk);
    chk("t1_held_off", key_held, 0);
    drain("t1_pending");
    chk("t1_tecla", tecla, 6);

    // Bouncing '1', never stable long enough.
    wait_col(0);
    for (int i = 0; i < 5; i++) begin
      closed[0] = 1'b1;
      repeat (3) @(negedge clk);
      closed[0] = 1'b0;
      repeat (2) @(negedge clk);
    end
    changes = 0;
    pc = col;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (col != pc) changes++;
      pc = col;
    end
    chk("t2_rotate", int'(changes >= 4), 1);
    drain("t2_pending");
    chk("t2_held", key_held, 0);

    // '*' then 'D' on row 3.
    press(12, 30);
    repeat (16) @(negedge clk);
    press(15, 30);
    repeat (16) @(negedge clk);
    drain("t3_pending");
    chk("t3_tecla", tecla, 13);

    // '5' with a glitch during release debounce.
    press(5, 20);
    repeat (5) @(negedge clk);
    closed[5] = 1'b1;
    repeat (2) @(negedge clk);
    closed[5] = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_held_glitch", key_held, 1);
    repeat (5) @(negedge clk);
    chk("t4_held_off", key_held, 0);
    drain("t4_pending");

    // Reset while debouncing '1', key kept down.
    wait_col(0);
    closed[0] = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_col", col, 4'b1110);
    chk("t5_tecla", tecla, 0);
    chk("t5_ready", ready, 0);
    chk("t5_held", key_held, 0);
    reset = 1'b1;
    early = 0;
    for (int i = 0; i < DB + 2; i++) begin
      @(negedge clk);
      if (ready) early++;
    end
    chk("t5_early_ready", early, 0);
    exp_q.push_back(keymap[0]);
    repeat (20) @(negedge clk);
    closed[0] = 1'b0;
    repeat (16) @(negedge clk);
    drain("t5_pending");
    chk("t5_tecla_after", tecla, 1);

    // '5' held 100 cycles past acceptance.
    press(5, ACC + 100);
    repeat (16) @(negedge clk);
    drain("t6_pending");

    // Random keys and hold times.
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 15);
      h = $urandom_range(30, 80);
      m = (h + 2 - ACC) % RP;
      if (m <= 2 || m >= RP - 2) h += 4;
      press(k, h);
      repeat (16) @(negedge clk);
      chk("rnd_held", key_held, 0);
      chk("rnd_tecla", tecla, keymap[k]);
      drain("rnd_pending");
      repeat ($urandom_range(0, 7)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    drain("final_pending");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
